// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality helper for the modulo counter family.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // True when WIDTH/MODULUS describe a usable range: WIDTH >= 1 and 2 <= MODULUS <= 2^WIDTH.
  function automatic bit params_ok(input int width, input longint modulus);
    bit ok_v;
    if (width < 32'sd1) begin
      ok_v = 1'b0;
    end else if (width >= 32'sd62) begin
      ok_v = (modulus >= 64'sd2);
    end else begin
      ok_v = (modulus >= 64'sd2) && (modulus <= (64'sd1 <<< width));
    end
    return ok_v;
  endfunction

  function automatic bit mode_ok(input int mode);
    return (mode == MODE_WRAP) || (mode == MODE_SAT);
  endfunction

endpackage

// File: rtl/counter_32.sv
// Legacy fixed 5-bit wrapping up-counter with active-high reset, built on counter_mod.
module counter_32
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [4:0] count,
  output logic       tc,
  output logic       wrap,
  output logic       ovf
);

  logic rst_n_s;

  assign rst_n_s = ~rst;

  counter_mod #(
    .WIDTH   (5),
    .MODULUS (32),
    .SATURATE(MODE_WRAP)
  ) u_core (
    .clk     (clk),
    .rst     (rst_n_s),
    .en      (en),
    .up      (1'b1),
    .clear   (1'b0),
    .load    (1'b0),
    .load_val(5'd0),
    .count   (count),
    .tc      (tc),
    .wrap    (wrap),
    .ovf     (ovf)
  );

endmodule

// File: rtl/counter_mod_next.sv
// Combinational step logic: enabled next count, terminal count and range-end detection.
module counter_mod_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 32,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clear_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o,
  output logic             end_o
);

  // One extra bit keeps MODULUS = 2^WIDTH from truncating the end-of-range constant.
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] cnt_s;
  logic [WIDTH:0] step_s;
  logic           at_max_s;
  logic           at_zero_s;
  logic           end_s;
  logic           unused_top_s;

  // Step one position in the selected direction, wrapping or holding at the range ends.
  always_comb begin
    cnt_s     = {1'b0, count_i};
    at_max_s  = (cnt_s == MAX_W);
    at_zero_s = (cnt_s == ZERO_W);
    step_s    = cnt_s;
    end_s     = 1'b0;
    if (up_i) begin
      end_s = at_max_s;
      if (!at_max_s) begin
        step_s = cnt_s + ONE_W;
      end else if (SATURATE == MODE_SAT) begin
        step_s = MAX_W;
      end else begin
        step_s = ZERO_W;
      end
    end else begin
      end_s = at_zero_s;
      if (!at_zero_s) begin
        step_s = cnt_s - ONE_W;
      end else if (SATURATE == MODE_SAT) begin
        step_s = ZERO_W;
      end else begin
        step_s = MAX_W;
      end
    end
  end

  assign next_o       = step_s[WIDTH-1:0];
  assign unused_top_s = step_s[WIDTH];
  assign end_o        = end_s;
  assign tc_o         = en_i & ~clear_i & ~load_i & end_s;

endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with clear, load, wrap/saturate mode,
// terminal count, registered wrap pulse and sticky overflow.
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 32,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (!params_ok(WIDTH, longint'(MODULUS))) begin : g_bad_range
    $fatal(1, "counter_mod: illegal WIDTH/MODULUS combination");
  end
  if (!mode_ok(SATURATE)) begin : g_bad_mode
    $fatal(1, "counter_mod: SATURATE must be MODE_WRAP or MODE_SAT");
  end

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] next_s;
  logic             end_s;
  logic             load_big_s;

  counter_mod_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .count_i(count_q),
    .en_i   (en),
    .up_i   (up),
    .clear_i(clear),
    .load_i (load),
    .next_o (next_s),
    .tc_o   (tc),
    .end_o  (end_s)
  );

  // Priority mux: clear > load > enabled step > hold.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    ovf_d      = ovf_q;
    load_big_s = ({1'b0, load_val} >= MOD_W);
    if (clear) begin
      count_d = {WIDTH{1'b0}};
      ovf_d   = 1'b0;
    end else if (load) begin
      if (load_big_s) begin
        count_d = MAX_C;
        ovf_d   = 1'b1;
      end else begin
        count_d = load_val;
        ovf_d   = ovf_q;
      end
    end else if (en) begin
      count_d = next_s;
      wrap_d  = end_s;
      ovf_d   = ovf_q | end_s;
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= {WIDTH{1'b0}};
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: three configurations plus the counter_32 wrapper, all checked
// every cycle against a range-arithmetic model, with directed literal expectations.
module tb_counter_mod;

  logic       clk;
  logic       rst, en, up, clear, load;
  logic [4:0] lv;

  logic [4:0] count0, count3;
  logic [3:0] count1, count2;
  logic       tc0, tc1, tc2, tc3;
  logic       wrap0, wrap1, wrap2, wrap3;
  logic       ovf0, ovf1, ovf2, ovf3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int nwrap;
  bit armed = 1'b0;

  // model state and configuration per instance (3 = legacy wrapper)
  int MW[4] = '{5, 4, 4, 5};
  int MM[4] = '{32, 10, 10, 32};
  int MS[4] = '{0, 0, 1, 0};
  int mc[4];
  int mw[4];
  int mo[4];

  int exp2[5]  = '{2, 1, 0, 9, 8};
  int expw2[5] = '{0, 0, 0, 1, 0};
  int exp3[4]  = '{8, 9, 9, 9};
  int expw3[4] = '{0, 0, 1, 1};

  counter_mod #(.WIDTH(5), .MODULUS(32), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv), .count(count0), .tc(tc0), .wrap(wrap0), .ovf(ovf0));

  counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv[3:0]), .count(count1), .tc(tc1), .wrap(wrap1), .ovf(ovf1));

  counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv[3:0]), .count(count2), .tc(tc2), .wrap(wrap2), .ovf(ovf2));

  counter_32 u3 (
    .clk(clk), .rst(~rst), .en(en), .count(count3), .tc(tc3), .wrap(wrap3), .ovf(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_update();
    int  v;
    bit  e_up, e_clr, e_ld, at_end;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      e_up  = (i == 3) ? 1'b1 : up;
      e_clr = (i == 3) ? 1'b0 : clear;
      e_ld  = (i == 3) ? 1'b0 : load;
      if (!rst) begin
        mc[i] = 0; mw[i] = 0; mo[i] = 0;
        armed = 1'b1;
      end else if (e_clr) begin
        mc[i] = 0; mw[i] = 0; mo[i] = 0;
      end else if (e_ld) begin
        v = int'(lv) % (1 << MW[i]);
        if (v < MM[i]) mc[i] = v;
        else begin
          mc[i] = MM[i] - 1;
          mo[i] = 1;
        end
        mw[i] = 0;
      end else if (en) begin
        at_end = e_up ? (mc[i] == MM[i] - 1) : (mc[i] == 0);
        if (MS[i] == 1) mc[i] = e_up ? ((mc[i] + 1 > MM[i] - 1) ? MM[i] - 1 : mc[i] + 1)
                                    : ((mc[i] - 1 < 0) ? 0 : mc[i] - 1);
        else mc[i] = (mc[i] + (e_up ? 1 : MM[i] - 1)) % MM[i];
        mw[i] = at_end ? 1 : 0;
        if (at_end) mo[i] = 1;
      end else begin
        mw[i] = 0;
      end
    end
  endtask

  task automatic model_check();
    logic [31:0] ac[4], at[4], aw[4], ao[4];
    int tc_exp;
    bit e_up, e_clr, e_ld;
    ac = '{32'(count0), 32'(count1), 32'(count2), 32'(count3)};
    at = '{32'(tc0), 32'(tc1), 32'(tc2), 32'(tc3)};
    aw = '{32'(wrap0), 32'(wrap1), 32'(wrap2), 32'(wrap3)};
    ao = '{32'(ovf0), 32'(ovf1), 32'(ovf2), 32'(ovf3)};
    for (int i = 0; i < 4; i++) begin
      e_up  = (i == 3) ? 1'b1 : up;
      e_clr = (i == 3) ? 1'b0 : clear;
      e_ld  = (i == 3) ? 1'b0 : load;
      tc_exp = (en && !e_clr && !e_ld && (e_up ? (mc[i] == MM[i] - 1) : (mc[i] == 0))) ? 1 : 0;
      chk($sformatf("model cyc%0d u%0d count", cyc, i), ac[i], mc[i]);
      chk($sformatf("model cyc%0d u%0d tc", cyc, i), at[i], tc_exp);
      chk($sformatf("model cyc%0d u%0d wrap", cyc, i), aw[i], mw[i]);
      chk($sformatf("model cyc%0d u%0d ovf", cyc, i), ao[i], mo[i]);
    end
  endtask

  // Model tracks each rising edge; outputs are compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      if (armed) model_check();
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; lv = 5'd0;

    // reset, then free-running up count on the 32-entry counter
    tick();
    chk("rst count", count0, 0);
    chk("rst wrap", wrap0, 0);
    chk("rst ovf", ovf0, 0);
    en = 1'b1; up = 1'b0;
    #1;
    chk("rst tc", tc0, 1);
    tick();
    chk("rst hold count", count0, 0);
    rst = 1'b1; up = 1'b1;
    nwrap = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("up count k=%0d", k), count0, k % 32);
      if (wrap0 === 1'b1) begin
        nwrap++;
        chk("wrap with count", count0, 0);
      end
      if (k == 30) chk("tc low at 30", tc0, 0);
      if (k == 31) chk("tc high at 31", tc0, 1);
      if (k == 32) chk("ovf after wrap", ovf0, 1);
    end
    chk("wrap pulses", nwrap, 1);
    chk("ovf sticky", ovf0, 1);

    // non-power-of-2 down count through zero
    load = 1'b1; lv = 5'd3; up = 1'b0;
    tick();
    chk("m10 load 3", count1, 3);
    chk("m10 load wrap", wrap1, 0);
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("m10 down %0d", k), count1, exp2[k]);
      chk($sformatf("m10 down wrap %0d", k), wrap1, expw2[k]);
    end

    // saturate mode
    clear = 1'b1;
    tick();
    chk("sat clear ovf", ovf2, 0);
    clear = 1'b0; load = 1'b1; lv = 5'd7; up = 1'b1;
    tick();
    chk("sat load 7", count2, 7);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("sat up %0d", k), count2, exp3[k]);
      chk($sformatf("sat up wrap %0d", k), wrap2, expw3[k]);
    end
    chk("sat ovf", ovf2, 1);
    up = 1'b0;
    tick();
    chk("sat down 8", count2, 8);
    chk("sat down wrap", wrap2, 0);
    tick();
    chk("sat down 7", count2, 7);
    chk("sat ovf held", ovf2, 1);

    // priority: clear beats load and en, then load beats en
    load = 1'b1; lv = 5'd5;
    tick();
    chk("prio load 5", count1, 5);
    chk("prio ovf before", ovf1, 1);
    clear = 1'b1; lv = 5'd2; en = 1'b1; up = 1'b1;
    tick();
    chk("prio clear count", count1, 0);
    chk("prio clear ovf", ovf1, 0);
    clear = 1'b0;
    tick();
    chk("prio load no inc", count1, 2);

    // out-of-range load
    lv = 5'd12;
    tick();
    chk("oor count", count1, 9);
    chk("oor ovf", ovf1, 1);
    chk("oor wrap", wrap1, 0);
    chk("in-range load m32", count0, 12);
    chk("in-range ovf m32", ovf0, 0);
    #1;
    chk("tc masked by load", tc1, 0);
    load = 1'b0; clear = 1'b1;
    tick();
    chk("clear ovf", ovf1, 0);
    clear = 1'b0;

    // reset mid-operation
    load = 1'b1; lv = 5'd9;
    tick();
    load = 1'b0;
    tick();
    chk("pre-rst wrap", wrap1, 1);
    load = 1'b1; lv = 5'd6;
    tick();
    chk("pre-rst count", count1, 6);
    chk("pre-rst ovf", ovf1, 1);
    load = 1'b0; rst = 1'b0;
    tick();
    chk("mid rst count", count1, 0);
    chk("mid rst wrap", wrap1, 0);
    chk("mid rst ovf", ovf1, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("rst release no change", count1, 0);
    tick();
    chk("resume count", count1, 1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
